// File: rtl/stack_pkg.sv
// Shared opcodes, FSM state type and capacity helper for the TOS-cached operand stack.
package stack_pkg;

    localparam logic [2:0] OP_NOP         = 3'd0;
    localparam logic [2:0] OP_PUSH        = 3'd1;
    localparam logic [2:0] OP_POP         = 3'd2;
    localparam logic [2:0] OP_REPLACE     = 3'd3;
    localparam logic [2:0] OP_POP_REPLACE = 3'd4;
    localparam logic [2:0] OP_DUP         = 3'd5;
    localparam logic [2:0] OP_SWAP        = 3'd6;
    localparam logic [2:0] OP_RSVD        = 3'd7;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_REFILL = 1'b1
    } stack_state_e;

    // RAM entries plus the two cached registers
    function automatic int unsigned stack_cap(input int unsigned addr_width);
        return (32'd1 << addr_width) + 32'd2;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port RAM holding the stack entries below NOS; synchronous write, registered read.
module stack_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stack_tos_cache.sv
// Operand stack with TOS/NOS cached in registers and deeper entries in RAM.
// Define STACK_TOS_GUARD_EN to enable overflow/underflow checking and sticky error flags.
module stack_tos_cache
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  err_clear,
    output logic                  op_ready,
    output logic [DATA_WIDTH-1:0] tos_data,
    output logic [DATA_WIDTH-1:0] nos_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int unsigned CW  = ADDR_WIDTH + 1;
    localparam int unsigned CAP = stack_cap(ADDR_WIDTH);

    stack_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d, ready_q, ready_d;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    logic accept, ge2, ge3, is_full, is_pop, do_op;
    logic udf_fault, ovf_fault;

    assign accept  = op_valid && (state_q == ST_READY);
    assign ge2     = count_q >= CW'(2);
    assign ge3     = count_q >= CW'(3);
    assign is_full = count_q == CW'(CAP);
    assign is_pop  = (op == OP_POP) || (op == OP_POP_REPLACE);

`ifdef STACK_TOS_GUARD_EN
    logic need_one, need_two, grows;
    logic ovf_q, ovf_d, udf_q, udf_d;

    assign need_one  = (op == OP_POP) || (op == OP_REPLACE) || (op == OP_DUP);
    assign need_two  = (op == OP_POP_REPLACE) || (op == OP_SWAP);
    assign grows     = (op == OP_PUSH) || (op == OP_DUP);
    assign udf_fault = accept && ((need_one && (count_q == '0)) || (need_two && !ge2));
    assign ovf_fault = accept && !udf_fault && grows && is_full;

    // A fault in the same cycle as err_clear leaves the flag set
    always_comb begin
        ovf_d = (ovf_q && !err_clear) || ovf_fault;
        udf_d = (udf_q && !err_clear) || udf_fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
`else
    logic unused_err_clear;

    assign udf_fault        = 1'b0;
    assign ovf_fault        = 1'b0;
    assign unused_err_clear = err_clear;
    assign err_overflow     = 1'b0;
    assign err_underflow    = 1'b0;
`endif

    assign do_op = accept && !udf_fault && !ovf_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:  if (do_op && is_pop && ge3) state_d = ST_REFILL;
            ST_REFILL: state_d = ST_READY;
            default:   state_d = ST_READY;
        endcase
    end

    // Datapath and RAM control; the RAM read issued on a pop lands in NOS during REFILL
    always_comb begin
        tos_d     = tos_q;
        nos_d     = nos_q;
        count_d   = count_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = ADDR_WIDTH'(count_q - CW'(2));
        ram_wdata = nos_q;
        if (state_q == ST_REFILL) begin
            nos_d = ram_rdata;
        end
        if (do_op) begin
            case (op)
                OP_PUSH, OP_DUP: begin
                    ram_we  = ge2;
                    nos_d   = tos_q;
                    tos_d   = (op == OP_PUSH) ? push_data : tos_q;
                    count_d = count_q + CW'(1);
                end
                OP_POP, OP_POP_REPLACE: begin
                    ram_re   = ge3;
                    ram_addr = ADDR_WIDTH'(count_q - CW'(3));
                    tos_d    = (op == OP_POP) ? nos_q : push_data;
                    count_d  = count_q - CW'(1);
                end
                OP_REPLACE: tos_d = push_data;
                OP_SWAP: begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end
                default: ;
            endcase
        end
        empty_d = count_d == '0;
        full_d  = count_d == CW'(CAP);
        ready_d = state_d == ST_READY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q   <= '0;
            nos_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ready_q <= ready_d;
        end
    end

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign op_ready = ready_q;
    assign tos_data = tos_q;
    assign nos_data = nos_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: tb/tb_stack_tos_cache.sv
// Randomized bench for stack_tos_cache against a queue-based stack model, plus directed cases.
module tb_stack_tos_cache;
    import stack_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 2;
    localparam int          CAP = 6;

    logic          clk = 1'b0;
    logic          reset, op_valid, err_clear;
    logic [2:0]    op;
    logic [DW-1:0] push_data;
    logic          op_ready, empty, full, err_overflow, err_underflow;
    logic [DW-1:0] tos_data, nos_data;
    logic [AW:0]   count;

    stack_tos_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op            (op),
        .push_data     (push_data),
        .err_clear     (err_clear),
        .op_ready      (op_ready),
        .tos_data      (tos_data),
        .nos_data      (nos_data),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: stack contents (top at the end), readiness and sticky flags
    logic [DW-1:0] stk[$];
    bit m_ready = 1'b1;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min_count(input logic [2:0] o);
        if (o == OP_POP_REPLACE || o == OP_SWAP) return 2;
        if (o == OP_POP || o == OP_REPLACE || o == OP_DUP) return 1;
        return 0;
    endfunction

    task automatic model_step(input bit v, input logic [2:0] o, input logic [DW-1:0] d,
                              input bit clr, input bit rst);
        int n;
        logic [DW-1:0] t;
        bit fault;
        n = stk.size();
        fault = 1'b0;
        if (rst) begin
            stk.delete();
            m_ready = 1'b1;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            return;
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (v && m_ready) begin
            m_ready = 1'b1;
`ifdef STACK_TOS_GUARD_EN
            if (n < min_count(o)) begin
                m_udf = 1'b1;
                fault = 1'b1;
            end else if ((o == OP_PUSH || o == OP_DUP) && n == CAP) begin
                m_ovf = 1'b1;
                fault = 1'b1;
            end
`endif
            if (!fault) begin
                case (o)
                    OP_PUSH: stk.push_back(d);
                    OP_DUP:  stk.push_back(stk[n-1]);
                    OP_POP: begin
                        void'(stk.pop_back());
                        if (n >= 3) m_ready = 1'b0;
                    end
                    OP_POP_REPLACE: begin
                        void'(stk.pop_back());
                        stk[n-2] = d;
                        if (n >= 3) m_ready = 1'b0;
                    end
                    OP_REPLACE: stk[n-1] = d;
                    OP_SWAP: begin
                        t        = stk[n-1];
                        stk[n-1] = stk[n-2];
                        stk[n-2] = t;
                    end
                    default: ;
                endcase
            end
        end else begin
            m_ready = 1'b1;
        end
    endtask

    task automatic cyc(input bit v, input logic [2:0] o, input logic [DW-1:0] d,
                       input bit clr, input bit rst);
        op_valid  = v;
        op        = o;
        push_data = d;
        err_clear = clr;
        reset     = rst;
        @(posedge clk);
        model_step(v, o, d, clr, rst);
        @(negedge clk);
        op_valid  = 1'b0;
        err_clear = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [DW-1:0] d);
        cyc(1'b1, o, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1);
    endtask

    // Compare every cycle; TOS/NOS only where they hold defined entries
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",    32'(count), 32'(stk.size()));
            chk("empty",    32'(empty), 32'(stk.size() == 0));
            chk("full",     32'(full), 32'(stk.size() == CAP));
            chk("op_ready", 32'(op_ready), 32'(m_ready));
            chk("err_ovf",  32'(err_overflow), 32'(m_ovf));
            chk("err_udf",  32'(err_underflow), 32'(m_udf));
            if (stk.size() >= 1) chk("tos", 32'(tos_data), 32'(stk[stk.size()-1]));
            if (stk.size() >= 2 && m_ready) chk("nos", 32'(nos_data), 32'(stk[stk.size()-2]));
        end
    end

    initial begin
        logic [2:0]    ro;
        logic [DW-1:0] rd;
        bit            rv, rc, rr;
        op_valid = 1'b0; op = OP_NOP; push_data = '0; err_clear = 1'b0; reset = 1'b1;
        chk_en = 1'b1;

        do_reset();
        chk("rst_tos", 32'(tos_data), 32'h0);
        chk("rst_nos", 32'(nos_data), 32'h0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        do_op(OP_PUSH, 8'h11);
        do_op(OP_PUSH, 8'h22);
        do_op(OP_PUSH, 8'h33);
        chk("push3_tos", 32'(tos_data), 32'h33);
        chk("push3_nos", 32'(nos_data), 32'h22);
        chk("push3_cnt", 32'(count), 32'd3);
        do_op(OP_POP, 8'h00);
        chk("pop_tos", 32'(tos_data), 32'h22);
        chk("pop_rdy", 32'(op_ready), 32'd0);
        idle();
        chk("refill_nos", 32'(nos_data), 32'h11);
        chk("refill_rdy", 32'(op_ready), 32'd1);
        chk("refill_cnt", 32'(count), 32'd2);

        do_reset();
        do_op(OP_PUSH, 8'h05);
        do_op(OP_PUSH, 8'h07);
        do_op(OP_PUSH, 8'h09);
        do_op(OP_POP_REPLACE, 8'h10);
        chk("prep_tos", 32'(tos_data), 32'h10);
        chk("prep_cnt", 32'(count), 32'd2);
        idle();
        chk("prep_nos", 32'(nos_data), 32'h05);
        do_op(OP_SWAP, 8'h00);
        chk("swap_tos", 32'(tos_data), 32'h05);
        chk("swap_nos", 32'(nos_data), 32'h10);

`ifdef STACK_TOS_GUARD_EN
        do_reset();
        for (int i = 0; i < CAP; i++) do_op(OP_PUSH, 8'(8'hA0 + i));
        do_op(OP_PUSH, 8'hEE);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd6);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        chk("ovf_tos", 32'(tos_data), 32'hA5);
        chk("ovf_nos", 32'(nos_data), 32'hA4);
        cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0);
        chk("ovf_clr", 32'(err_overflow), 32'd0);
        for (int i = 0; i < CAP; i++) begin
            do_op(OP_POP, 8'h00);
            if (!m_ready) idle();
        end

        do_reset();
        do_op(OP_POP, 8'h00);
        chk("udf_pop", 32'(err_underflow), 32'd1);
        cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0);
        do_op(OP_PUSH, 8'h42);
        do_op(OP_SWAP, 8'h00);
        chk("udf_swap", 32'(err_underflow), 32'd1);
        chk("udf_cnt", 32'(count), 32'd1);
`endif

        do_reset();
        do_op(OP_PUSH, 8'h01);
        do_op(OP_PUSH, 8'h02);
        do_op(OP_PUSH, 8'h03);
        do_op(OP_POP, 8'h00);
        do_reset();
        chk("rref_tos", 32'(tos_data), 32'h0);
        chk("rref_nos", 32'(nos_data), 32'h0);
        chk("rref_cnt", 32'(count), 32'd0);
        chk("rref_rdy", 32'(op_ready), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            ro = 3'($urandom_range(0, 7));
            rd = 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 99) == 0);
            // Bias toward growing when shallow so the RAM gets exercised
            if (stk.size() < 3 && $urandom_range(0, 1) == 1) ro = OP_PUSH;
`ifndef STACK_TOS_GUARD_EN
            if (stk.size() < min_count(ro) ||
                ((ro == OP_PUSH || ro == OP_DUP) && stk.size() == CAP)) ro = OP_NOP;
`endif
            cyc(rv, ro, rd, rc, rr);
        end

`ifndef STACK_TOS_GUARD_EN
        do_reset();
        chk_en = 1'b0;
        do_op(OP_POP, 8'h00);
        chk("wrap_cnt", 32'(count), 32'd7);
        chk("wrap_ovf", 32'(err_overflow), 32'd0);
        chk("wrap_udf", 32'(err_underflow), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
